wb_master_arbiter: RTL and testbench
====================================

WB_MASTER_ARBITER -- requirements
Module: wb_master_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255, slave-ack watchdog limit in cycles (valid range 2..65535).
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 m0_adr_i/m0_dat_i/m0_sel_i/m0_we_i/m0_cyc_i/m0_stb_i  input  24/32/4/1/1/1  master 0 (FSMC bridge) Wishbone request.
REQ-005 m0_dat_o/m0_ack_o  output  32/1  master 0 read data and ack.
REQ-006 m1_adr_i/m1_dat_i/m1_sel_i/m1_we_i/m1_cyc_i/m1_stb_i  input  24/32/4/1/1/1  master 1 (on-chip DMA/test master) request.
REQ-007 m1_dat_o/m1_ack_o  output  32/1  master 1 read data and ack.
REQ-008 s_adr_o/s_dat_o/s_sel_o/s_we_o/s_cyc_o/s_stb_o  output  24/32/4/1/1/1  shared slave (SDRAM controller) request.
REQ-009 s_dat_i/s_ack_i  input  32/1  slave read data and ack.
REQ-010 timeout_o  output  1  sticky flag: a watchdog timeout has occurred since reset.

Function
REQ-011 Registered state machine, states IDLE, GNT0, GNT1; slave bus muxed combinationally from the registered grant.
REQ-012 IDLE: s_cyc_o=s_stb_o=s_we_o=0, s_adr_o=0, s_dat_o=0, s_sel_o=0; m0/m1 ack_o=0, dat_o=0.
REQ-013 IDLE -> GNTx on the cycle after mx_cyc_i is sampled high; arbitration decision is one cycle; no slave strobe in the decision cycle.
REQ-014 Both cyc high in IDLE: winner per REQ-025/026.
REQ-015 GNTx: s_* outputs = mx_* inputs; mx_dat_o = s_dat_i, mx_ack_o = s_ack_i; non-granted master sees ack_o=0, dat_o=0.
REQ-016 GNTx held while mx_cyc_i=1 regardless of the other master's requests (no preemption, bus lock for multi-beat cycles).
REQ-017 GNTx -> IDLE on the cycle mx_cyc_i is sampled low; minimum one IDLE cycle between grants.
REQ-018 Watchdog: 16-bit counter increments each GNTx cycle with mx_stb_i=1 and s_ack_i=0; cleared on s_ack_i, on mx_stb_i=0, and on entering IDLE.
REQ-019 Counter reaching TIMEOUT-1 with no ack: that cycle mx_ack_o=1, mx_dat_o=32'hDEAD_BEEF, s_cyc_o=s_stb_o=0 forced; timeout_o set; counter cleared; state stays GNTx until mx_cyc_i low.
REQ-020 s_ack_i coincident with timeout cycle: real ack wins, no timeout, timeout_o unchanged.
REQ-021 s_ack_i in IDLE is ignored (not routed to any master).
REQ-022 timeout_o cleared only by reset.

Reset
REQ-023 rst sampled high: state IDLE, watchdog 0, timeout_o 0, last-served pointer = master 1; all outputs take IDLE values next cycle.
REQ-024 Reset mid-transaction aborts it: s_cyc_o/s_stb_o low the cycle after rst sampled, no ack issued to either master.

Configuration
REQ-025 WB_ARB_ROUND_ROBIN_EN defined: contention in IDLE granted to the master not served last; last-served pointer updated on each IDLE->GNTx transition.
REQ-026 WB_ARB_ROUND_ROBIN_EN undefined: fixed priority, master 0 always wins contention; pointer logic absent.

Structure
REQ-027 Shared package wb_arb_pkg holds state encodings (IDLE=0, GNT0=1, GNT1=2), TIMEOUT_DATA 32'hDEAD_BEEF, widths ADR_W=24, DAT_W=32, SEL_W=4.
REQ-028 One sub-module, wb_arb_watchdog (counter, compare, sticky flag); grant FSM and mux stay in wb_master_arbiter.

Verification
REQ-029 m0 single read adr 24'h000010, slave acks 3 cycles after stb with 32'h1234_5678 -> m0_dat_o=32'h1234_5678 with m0_ack_o, m1_ack_o stays 0.
REQ-030 m0 and m1 cyc rise same cycle, each 4 transactions -> round-robin build: grants alternate m0,m1,m0,...; fixed build: all m0 first, then m1.
REQ-031 m1 holds cyc for 3-beat write while m0 requests -> m0 waits, granted one IDLE cycle after m1_cyc_i falls.
REQ-032 TIMEOUT=8, slave never acks m1 read -> m1_ack_o pulses on 8th strobe cycle with 32'hDEAD_BEEF, s_stb_o low that cycle, timeout_o=1 until rst.
REQ-033 TIMEOUT=8, slave ack on exactly the 8th cycle -> real data returned, timeout_o stays 0.
REQ-034 rst asserted mid-GNT0 with stb high -> s_cyc_o=0 next cycle, no ack to m0, state IDLE, next contention grants m0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared widths, grant state encoding and timeout data for the Wishbone arbiter
package wb_arb_pkg;
    localparam int ADR_W = 24;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;
    localparam int WDT_W = 16;
    localparam logic [DAT_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;
endpackage

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: slave-ack watchdog counter, timeout strobe and sticky timeout flag
module wb_arb_watchdog
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic act,
    input  logic ack,
    output logic fire,
    output logic flag
);
    localparam logic [WDT_W-1:0] LIM = WDT_W'(TIMEOUT - 1);

    logic [WDT_W-1:0] cnt;

    assign fire = act && !ack && cnt == LIM;

    // count unacked strobe cycles; any ack, idle strobe or timeout restarts the count
    always_ff @(posedge clk) begin
        if (rst || !act || ack || fire)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    // sticky flag, only reset clears it
    always_ff @(posedge clk) begin
        if (rst)
            flag <= 1'b0;
        else if (fire)
            flag <= 1'b1;
    end
endmodule

// File: rtl/wb_master_arbiter.sv
// wb_master_arbiter: two-master Wishbone arbiter with bus lock and ack watchdog; WB_ARB_ROUND_ROBIN_EN selects round-robin over fixed priority
module wb_master_arbiter
    import wb_arb_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic             m0_we_i,
    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic             m1_we_i,
    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic             s_we_o,
    output logic             s_cyc_o,
    output logic             s_stb_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    output logic             timeout_o
);
    state_t st, nx;
    logic   fire, act, pick0;

    assign act = (st == GNT0 && m0_stb_i) || (st == GNT1 && m1_stb_i);

    wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdt (
        .clk (clk),
        .rst (rst),
        .act (act),
        .ack (s_ack_i),
        .fire(fire),
        .flag(timeout_o)
    );

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic last;

    assign pick0 = m0_cyc_i && (!m1_cyc_i || last);

    // remember who was granted last; reset favours master 0 on first contention
    always_ff @(posedge clk) begin
        if (rst)
            last <= 1'b1;
        else if (st == IDLE && nx != IDLE)
            last <= (nx == GNT1);
    end
`else
    assign pick0 = m0_cyc_i;
`endif

    // grant state register
    always_ff @(posedge clk) begin
        if (rst)
            st <= IDLE;
        else
            st <= nx;
    end

    // next grant and slave/master routing from the registered grant
    always_comb begin
        nx       = IDLE;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_dat_o = '0;
        case (st)
            IDLE: nx = pick0 ? GNT0 : m1_cyc_i ? GNT1 : IDLE;
            GNT0: begin
                nx       = m0_cyc_i ? GNT0 : IDLE;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_sel_o  = m0_sel_i;
                s_we_o   = m0_we_i;
                s_cyc_o  = m0_cyc_i && !fire;
                s_stb_o  = m0_stb_i && !fire;
                m0_ack_o = s_ack_i || fire;
                m0_dat_o = fire ? TIMEOUT_DATA : s_dat_i;
            end
            GNT1: begin
                nx       = m1_cyc_i ? GNT1 : IDLE;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_sel_o  = m1_sel_i;
                s_we_o   = m1_we_i;
                s_cyc_o  = m1_cyc_i && !fire;
                s_stb_o  = m1_stb_i && !fire;
                m1_ack_o = s_ack_i || fire;
                m1_dat_o = fire ? TIMEOUT_DATA : s_dat_i;
            end
            default: nx = IDLE;
        endcase
    end
endmodule

// File: tb/tb_wb_master_arbiter.sv
// tb_wb_master_arbiter: directed self-checking bench for wb_master_arbiter (TIMEOUT=8)
module tb_wb_master_arbiter;
    import wb_arb_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [ADR_W-1:0] m0_adr_i, m1_adr_i, s_adr_o;
    logic [DAT_W-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
    logic [SEL_W-1:0] m0_sel_i, m1_sel_i, s_sel_o;
    logic             m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o;
    logic             m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o;
    logic             s_we_o, s_cyc_o, s_stb_o, s_ack_i, timeout_o;

    int total = 0;
    int bad   = 0;
    int n0, n1, w;
    logic g;
    logic exp_g;

    always #5 clk = ~clk;

    wb_master_arbiter #(.TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .timeout_o(timeout_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all;
        m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        s_ack_i = 0; s_dat_i = '0;
    endtask

    task automatic do_reset;
        rst = 1;
        idle_all();
        tick();
        tick();
        rst = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got=running exp=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        idle_all();
        rst = 1;
        tick();
        tick();
        @(negedge clk);
        check("rst_cyc", s_cyc_o, 0);
        check("rst_adr", s_adr_o, 0);
        check("rst_to", timeout_o, 0);
        check("rst_ack0", m0_ack_o, 0);

        // single read by m0, ack arrives in the 4th strobe cycle
        do_reset();
        m0_adr_i = 24'h000010; m0_sel_i = 4'hF; m0_cyc_i = 1; m0_stb_i = 1;
        s_ack_i = 1;
        @(negedge clk);
        check("dec_stb", s_stb_o, 0);
        check("idle_ack0", m0_ack_o, 0);
        check("idle_ack1", m1_ack_o, 0);
        tick();
        s_ack_i = 0;
        @(negedge clk);
        check("rd_stb", s_stb_o, 1);
        check("rd_adr", s_adr_o, 24'h000010);
        check("rd_sel", s_sel_o, 4'hF);
        tick();
        tick();
        tick();
        s_ack_i = 1; s_dat_i = 32'h1234_5678;
        @(negedge clk);
        check("rd_ack0", m0_ack_o, 1);
        check("rd_dat0", m0_dat_o, 32'h1234_5678);
        check("rd_ack1", m1_ack_o, 0);
        check("rd_dat1", m1_dat_o, 0);
        tick();
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        tick();

        // contention: both masters issue 4 single transactions
        do_reset();
        m0_adr_i = 24'h000100; m1_adr_i = 24'h000200;
        n0 = 4; n1 = 4;
        m0_cyc_i = 1; m0_stb_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        for (int t = 0; t < 8; t++) begin
            w = 0;
            @(negedge clk);
            while (!s_cyc_o && w < 10) begin
                @(negedge clk);
                w++;
            end
            check("arb_wait", 32'(w < 10), 1);
            g = (s_adr_o == 24'h000200);
`ifdef WB_ARB_ROUND_ROBIN_EN
            exp_g = (t % 2) == 1;
`else
            exp_g = t >= 4;
`endif
            check($sformatf("arb_order%0d", t), g, exp_g);
            #1 s_ack_i = 1; s_dat_i = 32'(t);
            #1 check($sformatf("arb_ack%0d", t), g ? m1_ack_o : m0_ack_o, 1);
            tick();
            s_ack_i = 0;
            if (g) begin
                m1_cyc_i = 0; m1_stb_i = 0; n1--;
            end else begin
                m0_cyc_i = 0; m0_stb_i = 0; n0--;
            end
            tick();
            m0_cyc_i = n0 > 0; m0_stb_i = n0 > 0;
            m1_cyc_i = n1 > 0; m1_stb_i = n1 > 0;
        end

        // m1 locks the bus for a 3-beat write while m0 waits
        do_reset();
        m1_adr_i = 24'h000300; m1_dat_i = 32'hA5A5_0001; m1_we_i = 1; m1_cyc_i = 1; m1_stb_i = 1;
        tick();
        m0_adr_i = 24'h000400; m0_cyc_i = 1; m0_stb_i = 1; s_ack_i = 1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            check($sformatf("lock_adr%0d", b), s_adr_o, 24'h000300);
            check($sformatf("lock_we%0d", b), s_we_o, 1);
            check($sformatf("lock_ack0_%0d", b), m0_ack_o, 0);
            check($sformatf("lock_ack1_%0d", b), m1_ack_o, 1);
            tick();
        end
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0; s_ack_i = 0;
        @(negedge clk);
        check("lock_drop", s_cyc_o, 0);
        tick();
        @(negedge clk);
        check("lock_gap", s_cyc_o, 0);
        tick();
        @(negedge clk);
        check("lock_next_cyc", s_cyc_o, 1);
        check("lock_next_adr", s_adr_o, 24'h000400);

        // watchdog: slave never acks an m1 read
        do_reset();
        m1_adr_i = 24'h000500; m1_cyc_i = 1; m1_stb_i = 1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 7) begin
                check("wd_pre_ack", m1_ack_o, 0);
                check("wd_pre_stb", s_stb_o, 1);
            end
            if (k == 8) begin
                check("wd_ack", m1_ack_o, 1);
                check("wd_dat", m1_dat_o, 32'hDEAD_BEEF);
                check("wd_stb", s_stb_o, 0);
                check("wd_cyc", s_cyc_o, 0);
                check("wd_ack0", m0_ack_o, 0);
            end
        end
        @(negedge clk);
        check("wd_flag", timeout_o, 1);
        check("wd_after_ack", m1_ack_o, 0);
        check("wd_after_stb", s_stb_o, 1);
        tick();
        m1_cyc_i = 0; m1_stb_i = 0;
        tick();
        tick();
        @(negedge clk);
        check("wd_sticky", timeout_o, 1);

        // real ack on the would-be timeout cycle wins
        do_reset();
        @(negedge clk);
        check("wd_rst_clr", timeout_o, 0);
        tick();
        m1_adr_i = 24'h000500; m1_cyc_i = 1; m1_stb_i = 1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            if (k == 8) begin
                s_ack_i = 1; s_dat_i = 32'hCAFE_F00D;
            end
            @(negedge clk);
            if (k == 8) begin
                check("ack8_ack", m1_ack_o, 1);
                check("ack8_dat", m1_dat_o, 32'hCAFE_F00D);
                check("ack8_stb", s_stb_o, 1);
            end
        end
        tick();
        s_ack_i = 0; m1_cyc_i = 0; m1_stb_i = 0;
        @(negedge clk);
        check("ack8_flag", timeout_o, 0);

        // reset in the middle of an m0 strobe aborts it
        do_reset();
        m0_adr_i = 24'h000600; m0_cyc_i = 1; m0_stb_i = 1;
        tick();
        @(negedge clk);
        check("mid_cyc", s_cyc_o, 1);
        tick();
        rst = 1;
        tick();
        rst = 0;
        m1_adr_i = 24'h000700; m1_cyc_i = 1; m1_stb_i = 1;
        @(negedge clk);
        check("abort_cyc", s_cyc_o, 0);
        check("abort_stb", s_stb_o, 0);
        check("abort_ack0", m0_ack_o, 0);
        tick();
        @(negedge clk);
        check("post_rst_adr", s_adr_o, 24'h000600);
        check("post_rst_cyc", s_cyc_o, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
